// File: rtl/gf_seq_reducer.sv
// Bit-serial GF(2^m) reducer: folds a 2W-bit carry-less product modulo the
// supplied polynomial one product bit per clock, then hands out the residue.
module gf_seq_reducer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*DATA_WIDTH-1:0]       reduc_in,
  input  logic [DATA_WIDTH:0]           polyn_red_in,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out,
  output logic                          err
);

  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int IW = $clog2(2 * DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_next;
  logic [2*DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH:0]     poly;
  logic [GW-1:0]           m;
  logic [IW-1:0]           idx;

  logic                    accept;
  logic                    grade_ok;
  logic                    last_step;
  logic [DATA_WIDTH:0]     poly_mask;
  logic [IW-1:0]           shift_amt;
  logic [2*DATA_WIDTH-1:0] poly_shifted;
  logic [2*DATA_WIDTH-1:0] rem_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = grade_ok ? RUN : DONE;
        end
      end
      RUN: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Coefficients above the grade are dropped so they can never leak into the fold.
  always_comb begin
    grade_ok  = (polyn_grade != '0) && (polyn_grade <= GW'(DATA_WIDTH));
    poly_mask = '0;
    for (int k = 0; k <= DATA_WIDTH; k++) begin
      poly_mask[k] = (k <= int'(polyn_grade));
    end
  end

  always_comb begin
    last_step    = (idx == IW'(m));
    shift_amt    = idx - IW'(m);
    poly_shifted = {{(DATA_WIDTH-1){1'b0}}, poly} << shift_amt;
    rem_step     = rem[idx] ? (rem ^ poly_shifted) : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      poly <= '0;
      m    <= '0;
      idx  <= '0;
      out  <= '0;
      err  <= 1'b0;
    end else if (accept) begin
      rem  <= reduc_in;
      poly <= polyn_red_in & poly_mask;
      m    <= polyn_grade;
      idx  <= IW'(2*DATA_WIDTH-1);
      if (!grade_ok) begin
        out <= '0;
        err <= 1'b1;
      end
    end else if (state == RUN) begin
      rem <= rem_step;
      if (last_step) begin
        out <= rem_step[DATA_WIDTH-1:0];
        err <= 1'b0;
      end else begin
        idx <= idx - IW'(1);
      end
    end
  end

endmodule

// File: doc/gf_seq_reducer.md
Name: gf_seq_reducer

Overview:
- Sequential GF(2^m) polynomial reducer; sits directly downstream of the carry-less multiplier stage.
- Consumes the 2*DATA_WIDTH-bit carry-less product plus the reduction polynomial and its grade.
- Reduces the product bit-serially, one product bit per clock, and returns the residue through a valid/ready handshake.
- Replaces the wide combinational reduction tree when area matters more than latency.

Parameters:
- DATA_WIDTH, 32, field element width; largest supported polynomial grade is DATA_WIDTH.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept an operand bundle
- reduc_in  input  2*DATA_WIDTH  carry-less product to reduce
- polyn_red_in  input  DATA_WIDTH+1  reduction polynomial; bit k is the coefficient of x^k
- polyn_grade  input  $clog2(DATA_WIDTH)+1  polynomial degree m
- out_valid  output  1  residue valid
- out_ready  input  1  consumer accepts residue
- out  output  DATA_WIDTH  residue; bits at or above m are zero
- err  output  1  qualified by out_valid; set when the grade is illegal

Behaviour:
- Reset (asynchronous, any state): state=IDLE, out=0, out_valid=0, err=0, in_ready=1. Reset mid-operation discards the job; no output is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch reduc_in into remainder register rem[2W-1:0], and latch polyn_red_in and polyn_grade (m).
  - If m==0 or m>DATA_WIDTH: go to DONE with out=0, err=1.
  - Otherwise: set bit index i=2W-1 and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, if rem[i]==1 then rem ^= (poly << (i-m)), truncated to 2W bits.
  - If i==m, go to DONE and register out=rem[DATA_WIDTH-1:0], err=0. Otherwise i=i-1.
  - Exactly 2*DATA_WIDTH-m cycles in RUN, independent of data.
- DONE:
  - out_valid=1; out and err held stable.
  - On out_ready, go to IDLE and drop out_valid.
  - in_ready=0 in DONE, so there is no simultaneous accept and emit.
  - out and err keep their last value after the handshake until the next job completes.
- Latency:
  - Accept edge to out_valid high = 2*DATA_WIDTH-m+1 cycles.
  - Illegal grade: out_valid high 1 cycle after accept.
  - Earliest next accept is the cycle after the output handshake.
- Precondition: polyn_red_in[m]==1. Coefficients of polyn_red_in above m are ignored; the latched poly is masked to bits 0..m at accept.
- If reduc_in < 2^m, the residue equals reduc_in; the block still spends the full RUN latency.
- Input signals are ignored outside IDLE.
- out_ready asserted while out_valid==0 has no effect.

Test Plan:
- DATA_WIDTH=8, poly=0x11B, m=8, reduc_in=0x2B79 (0x57 clmul 0x83) -> out=0xC1, err=0, out_valid exactly 9 cycles after accept.
- DATA_WIDTH=8, poly=0x13, m=4, reduc_in=0x0010 -> out=0x03; reduc_in=0x0005 -> out=0x05 unchanged; each with out_valid 13 cycles after accept.
- DATA_WIDTH=8, m=0, then m=9 -> err=1, out=0, out_valid 1 cycle after accept; a following legal job (0x11B, 0x2B79) -> out=0xC1, err=0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out and out_valid stable and in_ready=0 throughout; in_valid pulses during that window are not accepted.
- Assert rst for 1 cycle mid-RUN -> out_valid=0, out=0, in_ready=1 immediately; a new job afterwards completes with correct value and latency.
- Random regression (DATA_WIDTH=8 and 32, random m in 1..DATA_WIDTH, random poly with bit m set) -> out matches a reference polynomial-mod model and latency equals 2*DATA_WIDTH-m+1.
